// File: rtl/gate_tt_checker.sv
// gate_tt_checker: sweeps every input combination of a small combinational
// gate under test (GUT) and compares each response against a truth table.
// Each vector is driven on p, held for SETTLE cycles, and then sampled on s
// in one SAMPLE cycle. The block reports a mismatch count, a per-vector fail
// mask, and pass/done flags.

module gate_tt_checker #(
   parameter int unsigned            N_IN   = 1,
   parameter logic [(2**N_IN)-1:0]   TT     = 2'b01,
   parameter int unsigned            SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 abort,
   output logic [N_IN-1:0]      p,
   input  logic                 s,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [N_IN:0]        err_cnt,
   output logic [(2**N_IN)-1:0] fail_vec
);

   localparam int unsigned V = 2**N_IN;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_SAMPLE,
      S_DONE
   } state_t;

   // The settle counter is 4 bits wide, so the largest SETTLE value is 15.
   localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);
   localparam logic [N_IN-1:0] IDX_LAST  = N_IN'(V - 1);
   // With no settle window, a vector goes directly to its SAMPLE cycle.
   localparam state_t          VEC_FIRST = (SETTLE == 0) ? S_SAMPLE : S_WAIT;

   state_t          state;
   logic [N_IN-1:0] idx;
   logic [3:0]      cnt;

   // Result of the current sample. These signals are used only in S_SAMPLE.
   logic            miss;
   logic [N_IN:0]   err_next;
   logic [V-1:0]    fail_next;

   // Compare the current response with the expected truth-table entry.
   always_comb begin
      miss      = (s != TT[idx]);
      err_next  = err_cnt + (N_IN+1)'(miss);
      fail_next = fail_vec | (V'(miss) << idx);
   end

   // This block holds the sweep sequencer and all outputs. Every output is a register.
   // NOTE: all state uses non-blocking assignments so that each branch reads the pre-edge values of idx/err_cnt/fail_vec.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         idx      <= '0;
         cnt      <= '0;
         p        <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         pass     <= 1'b0;
         err_cnt  <= '0;
         fail_vec <= '0;
      end else if (abort) begin
         // Abort has priority over start and works in every state.
         // Partial results are kept so they can be inspected after the abort.
         state <= S_IDLE;
         idx   <= '0;
         cnt   <= '0;
         p     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         pass  <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state    <= VEC_FIRST;
                  idx      <= '0;
                  cnt      <= SETTLE_LD;
                  p        <= '0;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  pass     <= 1'b0;
                  err_cnt  <= '0;
                  fail_vec <= '0;
               end
            end

            S_WAIT: begin
               // The counter starts at SETTLE, so this state lasts exactly SETTLE cycles.
               cnt <= cnt - 4'd1;
               if (cnt <= 4'd1) begin
                  state <= S_SAMPLE;
               end
            end

            S_SAMPLE: begin
               err_cnt  <= err_next;
               fail_vec <= fail_next;
               if (idx == IDX_LAST) begin
                  // This is the last vector. p keeps its final value while
                  // the block waits in DONE.
                  state <= S_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
               end else begin
                  state <= VEC_FIRST;
                  idx   <= idx + 1'b1;
                  p     <= idx + 1'b1;
                  cnt   <= SETTLE_LD;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gate_tt_checker.sv
// Bench for gate_tt_checker. It uses two instances: one with the default
// parameters (NOT truth table) and one with N_IN=2, TT=4'b0111, SETTLE=3
// (NAND truth table). Expected sweep results are queued when a sweep starts.
// A monitor for each instance pops the next expected result and compares it
// whenever done rises.

module tb_gate_tt_checker;

   typedef struct packed {
      logic [2:0] err;
      logic [3:0] fail;
      logic       pass;
   } exp_t;

   typedef enum int {G_NOT, G_ST0, G_BUF, G_NAND, G_NOR} gut_t;

   logic       clk;
   logic       rst_n;

   // Default-parameter instance
   logic       start1, abort1, s1, busy1, done1, pass1;
   logic [0:0] p1;
   logic [1:0] err1;
   logic [1:0] fail1;

   // Two-input instance
   logic       start2, abort2, s2, busy2, done2, pass2;
   logic [1:0] p2;
   logic [2:0] err2;
   logic [3:0] fail2;

   gut_t mode1, mode2;

   int total = 0;
   int bad   = 0;

   exp_t q1[$];
   exp_t q2[$];

   logic done1_q, done2_q;

   gate_tt_checker dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1),
      .p(p1), .s(s1), .busy(busy1), .done(done1), .pass(pass1),
      .err_cnt(err1), .fail_vec(fail1)
   );

   gate_tt_checker #(.N_IN(2), .TT(4'b0111), .SETTLE(3)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
      .p(p2), .s(s2), .busy(busy2), .done(done2), .pass(pass2),
      .err_cnt(err2), .fail_vec(fail2)
   );

   // Behavioral models of the gates under test
   always_comb begin
      case (mode1)
         G_NOT:   s1 = ~p1[0];
         G_ST0:   s1 = 1'b0;
         default: s1 = p1[0];
      endcase
      case (mode2)
         G_NOR:   s2 = ~(p2[1] | p2[0]);
         default: s2 = ~(p2[1] & p2[0]);
      endcase
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor for dut1: one expected entry per rising edge of done
   always @(negedge clk) begin
      if (done1 && !done1_q) begin
         if (q1.size() == 0) begin
            check("dut1 unexpected done", 1, 0);
         end else begin
            exp_t e;
            e = q1.pop_front();
            check("dut1 err_cnt",  {1'b0, err1}, e.err);
            check("dut1 fail_vec", {2'b00, fail1}, e.fail);
            check("dut1 pass",     pass1, e.pass);
            check("dut1 busy@done", busy1, 0);
         end
      end
      done1_q <= done1;
   end

   // Scoreboard monitor for dut2
   always @(negedge clk) begin
      if (done2 && !done2_q) begin
         if (q2.size() == 0) begin
            check("dut2 unexpected done", 1, 0);
         end else begin
            exp_t e;
            e = q2.pop_front();
            check("dut2 err_cnt",  err2, e.err);
            check("dut2 fail_vec", fail2, e.fail);
            check("dut2 pass",     pass2, e.pass);
            check("dut2 busy@done", busy2, 0);
         end
      end
      done2_q <= done2;
   end

   // Each pulse task returns at the negedge that follows the start-accept edge.
   task automatic pulse_start1();
      @(negedge clk); start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
   endtask

   task automatic pulse_start2();
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0;
   endtask

   task automatic wait_done1(input int max);
      int i;
      for (i = 0; i < max && !done1; i++) @(negedge clk);
      if (!done1) check("dut1 done timeout", 0, 1);
   endtask

   task automatic wait_done2(input int max);
      int i;
      for (i = 0; i < max && !done2; i++) @(negedge clk);
      if (!done2) check("dut2 done timeout", 0, 1);
   endtask

   // Default-parameter sweep with an exact latency check. p must follow
   // 0,0,1,1, and done must rise on the 4th edge after the accept edge.
   task automatic sweep1_exact(input string tag);
      pulse_start1();
      for (int k = 0; k < 4; k++) begin
         check({tag, " p"}, p1, k / 2);
         check({tag, " done early"}, done1, 0);
         check({tag, " busy"}, busy1, 1);
         @(negedge clk);
      end
      check({tag, " done@4"}, done1, 1);
   endtask

   initial begin
      rst_n  = 1'b0;
      start1 = 1'b0; abort1 = 1'b0;
      start2 = 1'b0; abort2 = 1'b0;
      mode1  = G_NOT;
      mode2  = G_NAND;
      done1_q = 1'b0;
      done2_q = 1'b0;

      // Reset state of both instances
      #3;
      check("rst p1", p1, 0);
      check("rst busy1", busy1, 0);
      check("rst done1", done1, 0);
      check("rst pass1", pass1, 0);
      check("rst err1", err1, 0);
      check("rst fail1", fail1, 0);
      check("rst p2", p2, 0);
      check("rst busy2", busy2, 0);
      check("rst done2", done2, 0);
      check("rst err2", err2, 0);
      check("rst fail2", fail2, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // NOT gate: every vector matches.
      mode1 = G_NOT;
      q1.push_back('{err: 3'd0, fail: 4'b0000, pass: 1'b1});
      sweep1_exact("not");

      // Stuck-at-0 output: vector 0 (expected 1) fails.
      mode1 = G_ST0;
      q1.push_back('{err: 3'd1, fail: 4'b0001, pass: 1'b0});
      sweep1_exact("st0");

      // Buffer: both vectors fail. A start during the sweep is ignored.
      mode1 = G_BUF;
      q1.push_back('{err: 3'd2, fail: 4'b0011, pass: 1'b0});
      pulse_start1();                         // at N0
      check("buf cleared err", err1, 0);
      check("buf cleared fail", fail1, 0);
      check("buf cleared done", done1, 0);
      @(negedge clk);                         // N1
      start1 = 1'b1;
      @(negedge clk);                         // N2: a start accepted here would restart the sweep
      start1 = 1'b0;
      check("buf busy kept", busy1, 1);
      check("buf p after ignored start", p1, 1);
      @(negedge clk);                         // N3
      check("buf done early", done1, 0);
      @(negedge clk);                         // N4
      check("buf done@4 with stray start", done1, 1);

      // Start a fresh sweep from DONE with the NOT gate restored.
      mode1 = G_NOT;
      q1.push_back('{err: 3'd0, fail: 4'b0000, pass: 1'b1});
      pulse_start1();
      check("restart err cleared", err1, 0);
      check("restart fail cleared", fail1, 0);
      check("restart pass cleared", pass1, 0);
      wait_done1(20);

      // Abort during the 3rd cycle of a buffer sweep
      mode1 = G_BUF;
      pulse_start1();                         // N0
      @(negedge clk);                         // N1
      @(negedge clk);                         // N2
      abort1 = 1'b1;
      @(negedge clk);                         // N3
      abort1 = 1'b0;
      check("abort busy", busy1, 0);
      check("abort done", done1, 0);
      check("abort pass", pass1, 0);
      check("abort p", p1, 0);
      check("abort err kept", err1, 1);
      check("abort fail kept", fail1, 2'b01);
      @(negedge clk);
      check("abort stays idle", busy1, 0);

      // Start and abort together in IDLE: abort wins.
      start1 = 1'b1; abort1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; abort1 = 1'b0;
      check("start+abort busy", busy1, 0);
      check("start+abort done", done1, 0);
      @(negedge clk);
      check("start+abort still idle", busy1, 0);
      check("start+abort err kept", err1, 1);

      // Two-input instance with the NAND gate: p steps every 4 cycles, and done rises on edge 16.
      mode2 = G_NAND;
      q2.push_back('{err: 3'd0, fail: 4'b0000, pass: 1'b1});
      pulse_start2();
      for (int k = 0; k < 16; k++) begin
         check("nand p", p2, k / 4);
         check("nand done early", done2, 0);
         @(negedge clk);
      end
      check("nand done@16", done2, 1);

      // Two-input instance with a NOR gate: vectors 1 and 2 mismatch.
      mode2 = G_NOR;
      q2.push_back('{err: 3'd2, fail: 4'b0110, pass: 1'b0});
      pulse_start2();
      wait_done2(40);

      // Asynchronous reset between clock edges during a buffer sweep
      mode1 = G_BUF;
      pulse_start1();                         // N0: the accept edge was E0
      @(posedge clk);                         // E1
      @(posedge clk);                         // E2: vector 0 sampled, p becomes 1
      #2;
      check("pre-rst p", p1, 1);
      check("pre-rst err", err1, 1);
      rst_n = 1'b0;
      #1;                                     // still before the next clock edge
      check("async rst p", p1, 0);
      check("async rst busy", busy1, 0);
      check("async rst done", done1, 0);
      check("async rst pass", pass1, 0);
      check("async rst err", err1, 0);
      check("async rst fail", fail1, 0);
      check("async rst done2", done2, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post-rst idle busy", busy1, 0);
      check("post-rst idle done", done1, 0);
      check("post-rst idle p", p1, 0);

      repeat (2) @(negedge clk);
      check("dut1 scoreboard drained", q1.size(), 0);
      check("dut2 scoreboard drained", q2.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Watchdog: stops the run if the stimulus never completes.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/gate_tt_checker.md
Name: gate_tt_checker

Overview:
- Synthesizable stimulus generator and response checker for small combinational gates such as the team's NOT/NAND/NOR primitives.
- Sequences the gate-under-test (GUT) input through every combination and samples the GUT output after a settle window.
- Compares each sample against an expected truth table and reports an error count, a per-vector fail mask and pass/done.
- Sits on the driving side of a GUT, replacing hand-written display-based benches with a self-checking hardware block.

Parameters:
- N_IN, 1, GUT input width; vector count V = 2**N_IN; legal range 1..4.
- TT, 2'b01, expected truth table of width V; bit i = expected s when p == i (default = NOT gate).
- SETTLE, 1, wait cycles between driving p and sampling s; legal range 0..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to run a full sweep; accepted in IDLE or DONE only.
- abort  input  1  synchronous abort of a running sweep.
- p  output  N_IN  stimulus to GUT input.
- s  input  1  GUT response.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; held until next accepted start, abort or reset.
- pass  output  1  valid when done=1; 1 iff err_cnt == 0.
- err_cnt  output  N_IN+1  number of mismatching vectors, 0..V.
- fail_vec  output  V  bit i set iff vector i mismatched.

Behaviour:
- Reset, asynchronous and immediate, including mid-sweep: state=IDLE; p=0, busy=0, done=0, pass=0, err_cnt=0, fail_vec=0; idx and settle counter = 0.
- FSM states are IDLE, WAIT, SAMPLE and DONE.
- IDLE/DONE with start=1 and abort=0:
  - Next edge: idx=0, p=0, err_cnt=0, fail_vec=0, done=0, pass=0, busy=1.
  - Settle counter loads SETTLE.
  - Next state is WAIT if SETTLE>0, else SAMPLE.
- WAIT: counter decrements each cycle; when it reaches 1, next state is SAMPLE. WAIT lasts exactly SETTLE cycles.
- SAMPLE: lasts one cycle; s is sampled at the edge ending it.
  - If s != TT[idx]: err_cnt += 1 and fail_vec[idx] = 1.
  - If idx == V-1: next state DONE, busy=0, done=1, pass = (final err_cnt == 0), including this sample's result. p holds its last value.
  - Otherwise: idx += 1, p = idx+1, counter reloads SETTLE, next state WAIT (or SAMPLE if SETTLE==0).
- Latency:
  - Each vector occupies SETTLE+1 cycles.
  - done rises at the edge V*(SETTLE+1) edges after the start-accept edge.
  - Default parameters: done high 4 edges after accept.
- p is constant for the whole of WAIT+SAMPLE of a vector and changes only at vector boundaries.
- start while busy=1 is ignored and does not restart or alter the sweep.
- abort while busy=1:
  - Next edge: state=IDLE, busy=0, done=0, pass=0, p=0.
  - err_cnt and fail_vec retain partial results.
- abort in IDLE/DONE: returns to IDLE, clears done/pass, keeps err_cnt/fail_vec.
- start and abort in the same cycle: abort wins; start is dropped.
- err_cnt cannot overflow: width N_IN+1 holds V.
- idx wrap from V-1 never occurs; the sweep terminates in DONE.
- DONE is sticky until start, abort or reset. A start in DONE begins a fresh sweep with cleared results.

Test Plan:
- Default params, GUT = NOT (s=~p), pulse start -> p sequence 0,0,1,1 over 4 cycles; done=1 on 4th edge after accept; pass=1, err_cnt=0, fail_vec=2'b00, busy=0.
- Default params, GUT stuck-at-0 (s=0) -> err_cnt=1, fail_vec=2'b01, pass=0, done=1 at same cycle as the previous case.
- Default params, GUT = buffer (s=p) -> err_cnt=2, fail_vec=2'b11, pass=0; then a second start clears results and, with the NOT gate restored, yields pass=1.
- N_IN=2, TT=4'b0111, SETTLE=3, GUT = NAND -> p steps 0,1,2,3 every 4 cycles; done at 16th edge; pass=1. Repeat with a NOR model -> fail_vec=4'b0110, err_cnt=2.
- Mid-sweep controls, default params with the buffer GUT:
  - start during busy -> sweep unaffected.
  - abort asserted on the 3rd cycle -> next edge busy=0, done=0, p=0, err_cnt=1, fail_vec=2'b01 retained.
  - start+abort together in IDLE -> remains IDLE.
- Async reset asserted between clock edges mid-sweep -> all outputs 0 immediately without a clock edge; after release, IDLE until start.
